// File: rtl/ode_fixed_pkg.sv
// Shared fixed-point definitions for the ODE solver datapath (multiplier and adder).
// Word layout: {scale[2:0], two's-complement mantissa[12:0]}, value = mant / 2^scale.
package ode_fixed_pkg;

  localparam int WORD_W    = 16;
  localparam int MANT_W    = 13;
  localparam int SF_W      = 3;
  localparam int MAX_SCALE = 7;

  localparam logic [MANT_W-1:0] MANT_MAX = 13'h0FFF;
  localparam logic [MANT_W-1:0] MANT_MIN = 13'h1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_NORM = 2'd2,
    ST_DONE = 2'd3
  } mul_state_t;

  typedef struct packed {
    logic [SF_W-1:0]   scale;
    logic [MANT_W-1:0] mant;
  } fx_word_t;

  // Magnitude of a two's-complement mantissa; the most negative value maps to 2^(MANT_W-1).
  function automatic logic [MANT_W-1:0] mant_mag(input logic [MANT_W-1:0] m);
    return m[MANT_W-1] ? (~m + 1'b1) : m;
  endfunction

endpackage

// File: rtl/mul_normalize.sv
// Combinational normaliser: picks the largest scale whose mantissa still fits the word.
// Optional MUL_ROUND_NEAREST_EN selects round-half-up instead of truncating shifts.
module mul_normalize #(
  parameter int MANT_W = 13,
  parameter int SF_W   = 3
) (
  input  logic signed [2*MANT_W:0] i_p,
  input  logic [SF_W:0]            i_f,
  output logic [SF_W-1:0]          o_scale,
  output logic [MANT_W-1:0]        o_mant,
  output logic                     o_invalid
);
  import ode_fixed_pkg::*;

  localparam int PW = 2 * MANT_W + 1;
  localparam int XW = PW + 1;
  localparam int NK = 1 << (SF_W + 1);

  logic signed [XW-1:0] w_p_ext;
  logic [NK-1:0]        w_fits;
  logic [MANT_W-1:0]    w_mant [NK];
  logic [SF_W:0]        w_kmin;
  logic [SF_W:0]        w_k;
  logic                 w_found;

  // One spare bit so the rounding increment can never wrap the product.
  assign w_p_ext = {i_p[PW-1], i_p};
  assign w_kmin  = (i_f > (SF_W + 1)'(MAX_SCALE)) ? (i_f - (SF_W + 1)'(MAX_SCALE)) : '0;

  generate
    for (genvar gi = 0; gi < NK; gi++) begin : g_shift
      logic signed [XW-1:0] w_sh;
`ifdef MUL_ROUND_NEAREST_EN
      if (gi == 0) begin : g_exact
        assign w_sh = w_p_ext;
      end else begin : g_round
        localparam logic signed [XW-1:0] HALF = XW'(1) <<< (gi - 1);
        assign w_sh = (w_p_ext + HALF) >>> gi;
      end
`else
      assign w_sh = w_p_ext >>> gi;
`endif
      // Fits when every bit above the mantissa field is a copy of its sign bit.
      assign w_fits[gi] = (&w_sh[XW-1:MANT_W-1]) | ~(|w_sh[XW-1:MANT_W-1]);
      assign w_mant[gi] = w_sh[MANT_W-1:0];
    end
  endgenerate

  // Scan downward so the smallest admissible shift wins.
  always_comb begin
    w_found = 1'b0;
    w_k     = '0;
    for (int k = NK - 1; k >= 0; k--) begin
      if (w_fits[k] && (k >= int'(w_kmin)) && (k <= int'(i_f))) begin
        w_found = 1'b1;
        w_k     = (SF_W + 1)'(k);
      end
    end
  end

  always_comb begin
    o_invalid = ~w_found;
    o_scale   = '0;
    o_mant    = i_p[PW-1] ? MANT_MIN : MANT_MAX;
    if (w_found) begin
      o_scale = SF_W'(i_f - w_k);
      o_mant  = w_mant[w_k];
    end
  end

endmodule

// File: rtl/mul_seq_cs.sv
// Sequential signed scaled-fixed-point multiplier: 13-step shift-add on magnitudes,
// one normalise step, then a held result. Rounding mode set by MUL_ROUND_NEAREST_EN.
module mul_seq_cs #(
  parameter int MANT_W = 13,
  parameter int SF_W   = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SF_W+MANT_W-1:0]   in1,
  input  logic [SF_W+MANT_W-1:0]   in2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SF_W+MANT_W-1:0]   out,
  output logic                     invalid,
  output logic                     busy
);
  import ode_fixed_pkg::*;

  localparam int AW = 2 * MANT_W;
  localparam int CW = $clog2(MANT_W + 1);

  mul_state_t        r_state;
  logic [AW-1:0]     r_mcand;
  logic [AW-1:0]     r_acc;
  logic [MANT_W-1:0] r_mplier;
  logic              r_sgn;
  logic [SF_W:0]     r_f;
  logic [CW-1:0]     r_cnt;
  fx_word_t          r_out;
  logic              r_out_valid;
  logic              r_invalid;

  logic [MANT_W-1:0] w_m1;
  logic [MANT_W-1:0] w_m2;
  logic [SF_W:0]     w_f;
  logic signed [AW:0] w_p;
  logic [SF_W-1:0]   w_scale;
  logic [MANT_W-1:0] w_mant;
  logic              w_invalid;

  assign w_m1 = in1[MANT_W-1:0];
  assign w_m2 = in2[MANT_W-1:0];
  assign w_f  = {1'b0, in1[SF_W+MANT_W-1:MANT_W]} + {1'b0, in2[SF_W+MANT_W-1:MANT_W]};

  // Re-apply the sign only once the unsigned magnitude product is complete.
  assign w_p = r_sgn ? -{1'b0, r_acc} : {1'b0, r_acc};

  mul_normalize #(
    .MANT_W (MANT_W),
    .SF_W   (SF_W)
  ) u_norm (
    .i_p       (w_p),
    .i_f       (r_f),
    .o_scale   (w_scale),
    .o_mant    (w_mant),
    .o_invalid (w_invalid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_mcand     <= '0;
      r_acc       <= '0;
      r_mplier    <= '0;
      r_sgn       <= 1'b0;
      r_f         <= '0;
      r_cnt       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_invalid   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_mcand  <= AW'(mant_mag(w_m1));
            r_mplier <= mant_mag(w_m2);
            r_sgn    <= w_m1[MANT_W-1] ^ w_m2[MANT_W-1];
            r_f      <= w_f;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= ST_MUL;
          end
        end
        ST_MUL: begin
          if (r_mplier[0]) begin
            r_acc <= r_acc + r_mcand;
          end
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == CW'(MANT_W - 1)) begin
            r_state <= ST_NORM;
          end
        end
        ST_NORM: begin
          r_out.scale <= w_scale;
          r_out.mant  <= w_mant;
          r_invalid   <= w_invalid;
          r_out_valid <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign invalid   = r_invalid;

endmodule

// File: tb/tb_mul_seq_cs.sv
// Self-checking bench for mul_seq_cs: directed test-plan vectors, randomized operands
// against an arithmetic reference model, back-pressure, mid-operation reset, throughput.
module tb_mul_seq_cs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in1 = 16'h0;
  logic [15:0] in2 = 16'h0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out;
  logic        invalid;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mul_seq_cs dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .invalid   (invalid),
    .busy      (busy)
  );

  // Reference: value = m / 2^s; search the smallest shift keeping the mantissa in range.
  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] o, output logic inv);
    logic signed [12:0] ma;
    logic signed [12:0] mb;
    longint p;
    longint v;
    int     f;
    int     kmin;
    bit     found;
    ma = a[12:0];
    mb = b[12:0];
    p  = longint'(ma) * longint'(mb);
    f  = int'(a[15:13]) + int'(b[15:13]);
    kmin = (f > 7) ? f - 7 : 0;
    found = 1'b0;
    o = 16'h0;
    inv = 1'b0;
    for (int k = kmin; k <= f; k++) begin
      if (!found) begin
`ifdef MUL_ROUND_NEAREST_EN
        if (k > 0) v = (p + (longint'(1) << (k - 1))) >>> k;
        else       v = p;
`else
        v = p >>> k;
`endif
        if (v >= -4096 && v <= 4095) begin
          found = 1'b1;
          o = {3'(f - k), 13'(v)};
          inv = 1'b0;
        end
      end
    end
    if (!found) begin
      o = (p < 0) ? 16'h1000 : 16'h0FFF;
      inv = 1'b1;
    end
  endfunction

  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    in1 = a;
    in2 = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in1 = 16'($urandom);
    in2 = 16'($urandom);
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (out !== 16'h0)      begin n_fail++; $display("FAIL reset_out got %h want 0000", out); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (invalid !== 1'b0)   begin n_fail++; $display("FAIL reset_invalid got %b want 0", invalid); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
    $display("reset released: in_ready=%b busy=%b", in_ready, busy);
  endtask

  task automatic test_directed();
    logic [15:0] va [9];
    logic [15:0] vb [9];
    logic [15:0] vo [9];
    logic        vi [9];
    int lat;
    va[0] = 16'h2003; vb[0] = 16'h0002; vo[0] = 16'h2006; vi[0] = 1'b0;
    va[1] = 16'h1FFF; vb[1] = 16'h2001; vo[1] = 16'h3FFF; vi[1] = 1'b0;
    va[2] = 16'hE0E0; vb[2] = 16'hE0E0; vo[2] = 16'hE188; vi[2] = 1'b0;
    va[3] = 16'h0FFF; vb[3] = 16'h0FFF; vo[3] = 16'h0FFF; vi[3] = 1'b1;
    va[4] = 16'h1000; vb[4] = 16'h1000; vo[4] = 16'h0FFF; vi[4] = 1'b1;
    va[5] = 16'h0FFF; vb[5] = 16'h1000; vo[5] = 16'h1000; vi[5] = 1'b1;
`ifdef MUL_ROUND_NEAREST_EN
    va[6] = 16'hE001; vb[6] = 16'hE0FF; vo[6] = 16'hE002; vi[6] = 1'b0;
`else
    va[6] = 16'hE001; vb[6] = 16'hE0FF; vo[6] = 16'hE001; vi[6] = 1'b0;
`endif
    va[7] = 16'h4000; vb[7] = 16'hC005; vo[7] = 16'hE000; vi[7] = 1'b0;
    va[8] = 16'h2000; vb[8] = 16'h4007; vo[8] = 16'h6000; vi[8] = 1'b0;
    for (int i = 0; i < 9; i++) begin
      start_op(va[i], vb[i]);
      wait_result(lat);
      $display("directed %0d: %h x %h -> out=%h invalid=%b latency=%0d", i, va[i], vb[i], out, invalid, lat);
      n_checks++; if (lat !== 14)        begin n_fail++; $display("FAIL dir_latency[%0d] got %0d want 14", i, lat); end
      n_checks++; if (out !== vo[i])     begin n_fail++; $display("FAIL dir_out[%0d] got %h want %h", i, out, vo[i]); end
      n_checks++; if (invalid !== vi[i]) begin n_fail++; $display("FAIL dir_invalid[%0d] got %b want %b", i, invalid, vi[i]); end
      release_result();
    end
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] eo;
    logic        ei;
    int lat;
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      case ($urandom_range(0, 5))
        0: a[12:0] = 13'h1000;
        1: b[12:0] = 13'h0FFF;
        2: a[12:0] = 13'h0000;
        3: b[12:0] = 13'h1FFF;
        default: ;
      endcase
      model(a, b, eo, ei);
      start_op(a, b);
      wait_result(lat);
      $display("random %0d: %h x %h -> out=%h invalid=%b expect=%h/%b", i, a, b, out, invalid, eo, ei);
      n_checks++; if (lat !== 14)     begin n_fail++; $display("FAIL rnd_latency[%0d] got %0d want 14", i, lat); end
      n_checks++; if (out !== eo)     begin n_fail++; $display("FAIL rnd_out[%0d] got %h want %h", i, out, eo); end
      n_checks++; if (invalid !== ei) begin n_fail++; $display("FAIL rnd_invalid[%0d] got %b want %b", i, invalid, ei); end
      release_result();
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] eo;
    logic        ei;
    int lat;
    model(16'hE0E0, 16'hE0E0, eo, ei);
    start_op(16'hE0E0, 16'hE0E0);
    wait_result(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0);
      in1 = 16'h2003;
      in2 = 16'h0002;
      @(posedge clk);
      #1;
      n_checks++; if (out !== eo)         begin n_fail++; $display("FAIL hold_out[%0d] got %h want %h", i, out, eo); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d] got %b want 1", i, out_valid); end
      n_checks++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL hold_in_ready[%0d] got %b want 0", i, in_ready); end
    end
    in_valid = 1'b0;
    release_result();
    $display("backpressure: released out=%h out_valid=%b in_ready=%b", out, out_valid, in_ready);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
    n_checks++; if (out !== eo)         begin n_fail++; $display("FAIL bp_release_out got %h want %h", out, eo); end
    // out_ready in IDLE must not disturb anything, and no pulsed operand was queued.
    @(negedge clk);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL bp_idle_busy got %b want 0", busy); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_idle_valid got %b want 0", out_valid); end
    n_checks++; if (out !== eo)         begin n_fail++; $display("FAIL bp_idle_out got %h want %h", out, eo); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] eo;
    logic        ei;
    int lat;
    start_op(16'h0FFF, 16'h0FFF);
    wait_result(lat);
    release_result();
    start_op(16'h4123, 16'h2456);
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    $display("reset mid-op: out=%h out_valid=%b invalid=%b busy=%b in_ready=%b", out, out_valid, invalid, busy, in_ready);
    n_checks++; if (out !== 16'h0)      begin n_fail++; $display("FAIL mid_rst_out got %h want 0000", out); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %b want 0", out_valid); end
    n_checks++; if (invalid !== 1'b0)   begin n_fail++; $display("FAIL mid_rst_invalid got %b want 0", invalid); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL mid_rst_busy got %b want 0", busy); end
    n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL mid_rst_in_ready got %b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_no_partial got %b want 0", out_valid); end
    model(16'h2003, 16'h0002, eo, ei);
    start_op(16'h2003, 16'h0002);
    wait_result(lat);
    $display("after reset: 2003 x 0002 -> out=%h invalid=%b latency=%0d", out, invalid, lat);
    n_checks++; if (lat !== 14)     begin n_fail++; $display("FAIL after_rst_latency got %0d want 14", lat); end
    n_checks++; if (out !== eo)     begin n_fail++; $display("FAIL after_rst_out got %h want %h", out, eo); end
    n_checks++; if (invalid !== ei) begin n_fail++; $display("FAIL after_rst_invalid got %b want %b", invalid, ei); end
    release_result();
  endtask

  task automatic test_back_to_back();
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] eo;
    logic        ei;
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      model(a, b, eo, ei);
      start_op(a, b);
      wait_result(lat);
      $display("b2b %0d: %h x %h -> out=%h invalid=%b latency=%0d", i, a, b, out, invalid, lat);
      n_checks++; if (lat !== 14)     begin n_fail++; $display("FAIL b2b_latency[%0d] got %0d want 14", i, lat); end
      n_checks++; if (out !== eo)     begin n_fail++; $display("FAIL b2b_out[%0d] got %h want %h", i, out, eo); end
      n_checks++; if (invalid !== ei) begin n_fail++; $display("FAIL b2b_invalid[%0d] got %b want %b", i, invalid, ei); end
      @(posedge clk);
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drop_valid[%0d] got %b want 0", i, out_valid); end
      n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL b2b_in_ready[%0d] got %b want 1", i, in_ready); end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_seq_cs.md
Name: mul_seq_cs

Overview:
- Sequential signed multiplier for the solver's scaled fixed-point word. Word layout: [15:13] scale s (unsigned, 0..7, the number of fractional bits) and [12:0] two's-complement mantissa m; value = m / 2^s.
- Sits directly upstream of the solver adder/subtractor and produces the h*f(x,y) terms it accumulates.
- Radix-2 shift-add on mantissa magnitudes, followed by a one-cycle normalise that picks the largest scale that still fits.

Parameters:
- MANT_W, 13, mantissa width. Only the default is verified.
- SF_W, 3, scale-factor width. Only the default is verified.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair present
- in_ready  output  1  block can accept operands
- in1  input  16  multiplicand word
- in2  input  16  multiplier word
- out_valid  output  1  result held valid
- out_ready  input  1  consumer takes the result
- out  output  16  product word {scale, mantissa}
- invalid  output  1  product unrepresentable, qualified by out_valid
- busy  output  1  state != IDLE

Behaviour:
- Reset: rst_n low asynchronously forces state IDLE and clears all outputs and internal registers: out=0, out_valid=0, invalid=0, busy=0, in_ready=1. Reset mid-operation abandons the operation; no partial result ever appears.
- States: IDLE, MUL, NORM, DONE.
- in_ready = (state == IDLE). Operands are accepted on an edge where in_valid && in_ready.
- Accept edge actions:
  - Latch |m1| and |m2| into 13-bit unsigned registers. Magnitude 4096 is legal.
  - Latch the sign flag sgn = m1[12] ^ m2[12].
  - Latch f = s1 + s2 (4 bits, 0..14).
  - Clear the 26-bit product accumulator and set count = 0. State goes to MUL.
- MUL: each edge adds the shifted multiplicand when the current multiplier bit is 1, then increments count. The edge on which count reaches 13 moves to NORM. That is 13 MUL edges.
- NORM, one edge:
  - Apply sgn (two's negate, 27-bit signed product P).
  - Let k_min = max(f-7, 0).
  - Choose the smallest k >= k_min such that P >>> k (arithmetic, i.e. truncation toward minus infinity) lies in [-4096, 4095].
  - If k <= f: out = {f-k, P>>>k}, invalid = 0.
  - Otherwise the result is saturated: out = {3'd0, 13'h0FFF} for positive P or {3'd0, 13'h1000} for negative P, with invalid = 1.
  - Zero product gives scale min(f,7) and mantissa 0.
  - State goes to DONE and out_valid is set to 1.
- Latency: out_valid rises on the 14th rising edge after the accepting edge.
- DONE: out, invalid and out_valid are held stable until out_ready is 1. On that edge out_valid goes to 0 and state goes to IDLE. out and invalid keep their last value.
- out_ready while in IDLE is ignored.
- in_valid while busy is ignored. Operands are not queued, and in1/in2 need not be held after acceptance.
- Throughput: at most one operation per 16 cycles (accept, 13 MUL, NORM, DONE with out_ready=1, then IDLE).

Optional Feature:
- Macro: MUL_ROUND_NEAREST_EN.
- Defined: in NORM, when k > 0, use (P + 2^(k-1)) >>> k (round half up) instead of truncation. The fit test is applied after rounding, so k may increase by 1 when rounding carries out. Same latency.
- Undefined: pure arithmetic-shift truncation as above.

Decomposition:
- Shared package ode_fixed_pkg holds:
  - constants WORD_W=16, MANT_W=13, SF_W=3, MAX_SCALE=7, MANT_MAX=13'h0FFF, MANT_MIN=13'h1000;
  - the state encoding for IDLE/MUL/NORM/DONE;
  - a word typedef with scale and mantissa fields.
- The downstream adder uses the same constants.
- One natural sub-module: mul_normalize. It is purely combinational: it takes P and f and returns scale, mantissa and invalid, and it contains the rounding macro. The FSM and datapath stay in mul_seq_cs.

Test Plan:
- 1.5 x 2.0: in1=16'h2003, in2=16'h0002 -> out=16'h2006, invalid=0, out_valid high exactly 14 edges after accept.
- -1.0 x 0.5: in1=16'h1FFF, in2=16'h2001 -> out=16'h3FFF (s=1, m=-1), invalid=0.
- Scale reduction, 1.75 x 1.75: in1=in2=16'hE0E0 -> f=14, k=7, out=16'hE188 (3.0625), invalid=0.
- Overflow:
  - 16'h0FFF x 16'h0FFF -> out=16'h0FFF, invalid=1.
  - 16'h1000 x 16'h1000 -> out=16'h0FFF, invalid=1.
  - 16'h0FFF x 16'h1000 -> out=16'h1000, invalid=1.
- Rounding, 16'hE001 x 16'hE0FF (product 255, k=7):
  - without MUL_ROUND_NEAREST_EN -> out=16'hE001;
  - with MUL_ROUND_NEAREST_EN -> out=16'hE002.
- Handshake/reset:
  - hold out_ready=0 for 5 cycles -> out and out_valid stable, in_ready=0; in_valid pulses during this window are not accepted.
  - assert rst_n=0 at MUL count=6 -> outputs clear immediately, in_ready=1; the next operation completes normally.
